// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// Shift-add multiply and restoring divide on operand magnitudes, sign-fixed at the end.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic             we_hi,
  input  logic             we_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  localparam logic [5:0] LastCnt = 6'(ITER - 1);

  state_e               state_q;
  logic [5:0]           cnt_q;
  logic                 is_div_q;
  logic                 neg_main_q;  // product or quotient needs negation
  logic                 neg_rem_q;
  logic                 div0_q;
  logic [WIDTH-1:0]     b_q;
  logic [WIDTH-1:0]     dividend_q;
  logic [2*WIDTH-1:0]   p_q;
  logic                 busy_q;
  logic                 done_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;

  logic                 sign1;
  logic                 sign2;
  logic [WIDTH-1:0]     mag1;
  logic [WIDTH-1:0]     mag2;

  assign sign1 = ~op[0] & operand1[WIDTH-1];
  assign sign2 = ~op[0] & operand2[WIDTH-1];
  assign mag1  = sign1 ? (WIDTH'(0) - operand1) : operand1;
  assign mag2  = sign2 ? (WIDTH'(0) - operand2) : operand2;

  // p_q holds {accumulator, multiplier} for multiply and {remainder, quotient} for divide.
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH-1:0]     div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   p_step;

  always_comb begin
    mul_sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? b_q : '0)};
    div_shift = p_q[2*WIDTH-1:WIDTH-1];
    div_ge    = div_shift >= {1'b0, b_q};
    // Modular subtraction is exact whenever div_ge holds.
    div_diff  = div_shift[WIDTH-1:0] - b_q;
    p_step    = '0;
    if (!is_div_q) begin
      p_step = {mul_sum, p_q[WIDTH-1:1]};
    end else if (div_ge) begin
      p_step = {div_diff, p_q[WIDTH-2:0], 1'b1};
    end else begin
      p_step = {div_shift[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
    end
  end

  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     res_hi;
  logic [WIDTH-1:0]     res_lo;

  always_comb begin
    prod   = '0;
    res_hi = '0;
    res_lo = '0;
    if (!is_div_q) begin
      prod   = neg_main_q ? ('0 - p_q) : p_q;
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (div0_q) begin
      res_hi = dividend_q;
      res_lo = '1;
    end else begin
      res_lo = neg_main_q ? (WIDTH'(0) - p_q[WIDTH-1:0]) : p_q[WIDTH-1:0];
      res_hi = neg_rem_q ? (WIDTH'(0) - p_q[2*WIDTH-1:WIDTH]) : p_q[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      div0_q     <= 1'b0;
      b_q        <= '0;
      dividend_q <= '0;
      p_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            is_div_q   <= op[1];
            neg_main_q <= sign1 ^ sign2;
            neg_rem_q  <= sign1;
            div0_q     <= op[1] & (operand2 == '0);
            dividend_q <= operand1;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= StRun;
            if (op[1]) begin
              p_q <= {{WIDTH{1'b0}}, mag1};
              b_q <= mag2;
            end else begin
              p_q <= {{WIDTH{1'b0}}, mag2};
              b_q <= mag1;
            end
          end else begin
            if (we_hi) hi_q <= wdata;
            if (we_lo) lo_q <= wdata;
          end
        end
        StRun: begin
          p_q   <= p_step;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q >= LastCnt) state_q <= StFinish;
        end
        StFinish: begin
          hi_q    <= res_hi;
          lo_q    <= res_lo;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
